// File: rtl/ldmx_reg_client.sv
`default_nettype none
// ============================================================================
// Module   : ldmx_reg_client
// Purpose  : Register-bank client behind a strobe/acknowledge merger. It
//            provides eight RW control words, a sampled status word, a
//            saturating event counter, a self-clearing pulse register and a
//            constant block ID.
// Ports    : axilClk / axilRst   - clock, synchronous active-high reset
//            rstr / raddr        - read strobe (level) and word address
//            rack / dout         - read acknowledge (level) and read data
//            wstr / waddr / wdata- write strobe (level), word address, data
//            wack                - write acknowledge (level)
//            ctrl                - control registers 0..7, packed 32b each
//            status_in           - live status word (RO offset 0x8)
//            count_in            - event pulse feeding the counter
//            pulse_out           - one-cycle action pulses (offset 0xA)
// Revision : 1.0 - initial release
// ============================================================================
module ldmx_reg_client #(
   parameter logic [31:0] CTRL_RESET = 32'h0,
   parameter logic [31:0] BLOCK_ID   = 32'h1D3A0001
) (
   input  logic          axilClk,
   input  logic          axilRst,
   input  logic          rstr,
   input  logic [17:0]   raddr,
   output logic          rack,
   output logic [31:0]   dout,
   input  logic          wstr,
   input  logic [17:0]   waddr,
   input  logic [31:0]   wdata,
   output logic          wack,
   output logic [255:0]  ctrl,
   input  logic [31:0]   status_in,
   input  logic          count_in,
   output logic [31:0]   pulse_out
);

   localparam logic [3:0] c_OFF_STATUS = 4'h8;
   localparam logic [3:0] c_OFF_COUNT  = 4'h9;
   localparam logic [3:0] c_OFF_PULSE  = 4'hA;
   localparam logic [3:0] c_OFF_ID     = 4'hB;

   // Read channel states: R_WAIT is the cycle after capture, R_ACK holds
   // the acknowledge until the merger drops its strobe.
   localparam logic [1:0] c_RD_IDLE = 2'd0;
   localparam logic [1:0] c_RD_WAIT = 2'd1;
   localparam logic [1:0] c_RD_ACK  = 2'd2;

   logic [255:0] r_ctrl;
   logic [31:0]  r_event_cnt;
   logic [31:0]  r_pulse;
   logic [31:0]  r_hold;
   logic         r_rstr_q;
   logic         r_wstr_q;
   logic         r_wack_q;
   logic [1:0]   r_rd_state;
   logic [1:0]   w_rd_next;
   logic         w_rack_q;
   logic         w_rd_start;
   logic         w_wr_start;
   logic [3:0]   w_roff;
   logic [3:0]   w_woff;
   logic [31:0]  w_rd_value;
   logic         w_unused_addr;

   assign w_roff = raddr[3:0];
   assign w_woff = waddr[3:0];

   // The upper address bits were already decoded by the merger.
   assign w_unused_addr = ^{raddr[17:4], waddr[17:4]};

   // Transactions start only on a strobe rising edge; a held strobe never
   // retriggers. History resets to 1 so a strobe already high when reset
   // releases must first be seen low.
   assign w_rd_start = rstr & ~r_rstr_q;
   assign w_wr_start = wstr & ~r_wstr_q;

   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_rstr_q <= 1'b1;
         r_wstr_q <= 1'b1;
      end else begin
         r_rstr_q <= rstr;
         r_wstr_q <= wstr;
      end
   end

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_ctrl <= {8{CTRL_RESET}};
      end else if (w_wr_start && !w_woff[3]) begin
         r_ctrl[{w_woff[2:0], 5'b0} +: 32] <= wdata;
      end
   end

   // A clear and an event in the same cycle leaves the counter at 1.
   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_event_cnt <= 32'h0;
      end else if (w_wr_start && (w_woff == c_OFF_COUNT)) begin
         r_event_cnt <= {31'h0, count_in};
      end else if (count_in && (r_event_cnt != 32'hFFFF_FFFF)) begin
         r_event_cnt <= r_event_cnt + 32'h1;
      end
   end

   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_pulse <= 32'h0;
      end else if (w_wr_start && (w_woff == c_OFF_PULSE)) begin
         r_pulse <= wdata;
      end else begin
         r_pulse <= 32'h0;
      end
   end

   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_wack_q <= 1'b0;
      end else if (w_wr_start) begin
         r_wack_q <= 1'b1;
      end else if (!wstr) begin
         r_wack_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   // Decode uses current register contents, so a same-cycle write to the
   // same register is captured with its pre-write value.
   always_comb begin
      w_rd_value = 32'h0;
      case (w_roff)
         4'h0, 4'h1, 4'h2, 4'h3,
         4'h4, 4'h5, 4'h6, 4'h7: w_rd_value = r_ctrl[{w_roff[2:0], 5'b0} +: 32];
         c_OFF_STATUS:           w_rd_value = status_in;
         c_OFF_COUNT:            w_rd_value = r_event_cnt;
         c_OFF_ID:               w_rd_value = BLOCK_ID;
         default:                w_rd_value = 32'h0;
      endcase
   end

   // Capture happens only on a rising edge, so the holding register cannot
   // change while the acknowledge is high.
   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_hold <= 32'h0;
      end else if (w_rd_start) begin
         r_hold <= w_rd_value;
      end
   end

   always_ff @(posedge axilClk) begin
      if (axilRst) begin
         r_rd_state <= c_RD_IDLE;
      end else begin
         r_rd_state <= w_rd_next;
      end
   end

   always_comb begin
      w_rd_next = r_rd_state;
      case (r_rd_state)
         c_RD_IDLE: if (w_rd_start) w_rd_next = c_RD_WAIT;
         c_RD_WAIT: w_rd_next = rstr ? c_RD_ACK : c_RD_IDLE;
         c_RD_ACK:  w_rd_next = rstr ? c_RD_ACK : c_RD_IDLE;
         default:   w_rd_next = c_RD_IDLE;
      endcase
   end

   always_comb begin
      w_rack_q = 1'b0;
      if (r_rd_state == c_RD_ACK) begin
         w_rack_q = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: acknowledges follow the strobe combinationally so they drop
   // in the very cycle the merger releases it, and are forced low in reset.
   // ------------------------------------------------------------------
   assign rack      = w_rack_q & rstr & ~axilRst;
   assign wack      = r_wack_q & wstr & ~axilRst;
   assign dout      = rack ? r_hold : 32'h0;
   assign ctrl      = r_ctrl;
   assign pulse_out = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ldmx_reg_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldmx_reg_client
// Purpose  : Self-checking bench for ldmx_reg_client. Directed scenarios for
//            the documented behaviours followed by randomized transactions
//            compared against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldmx_reg_client;

   localparam logic [31:0] c_CTRL_RESET = 32'hA5A5_0F0F;
   localparam logic [31:0] c_BLOCK_ID   = 32'h1D3A_0001;

   logic          axilClk;
   logic          axilRst;
   logic          rstr;
   logic [17:0]   raddr;
   logic          rack;
   logic [31:0]   dout;
   logic          wstr;
   logic [17:0]   waddr;
   logic [31:0]   wdata;
   logic          wack;
   logic [255:0]  ctrl;
   logic [31:0]   status_in;
   logic          count_in;
   logic [31:0]   pulse_out;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_ctrl [8];
   logic [31:0] m_cnt;
   bit          cnt_rand;

   initial axilClk = 1'b0;
   always #5 axilClk = ~axilClk;

   ldmx_reg_client #(
      .CTRL_RESET (c_CTRL_RESET),
      .BLOCK_ID   (c_BLOCK_ID)
   ) dut (
      .axilClk   (axilClk),
      .axilRst   (axilRst),
      .rstr      (rstr),
      .raddr     (raddr),
      .rack      (rack),
      .dout      (dout),
      .wstr      (wstr),
      .waddr     (waddr),
      .wdata     (wdata),
      .wack      (wack),
      .ctrl      (ctrl),
      .status_in (status_in),
      .count_in  (count_in),
      .pulse_out (pulse_out)
   );

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] off);
      case (off)
         4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: return m_ctrl[off[2:0]];
         4'h8:    return status_in;
         4'h9:    return m_cnt;
         4'hB:    return c_BLOCK_ID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [255:0] model_ctrl();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = m_ctrl[k];
      return v;
   endfunction

   // Ends the current cycle: advances the counter model with this cycle's
   // inputs, steps the clock, then drives fresh background inputs.
   task automatic cyc(input bit clr);
      if (axilRst) begin
         m_cnt = 32'h0;
         for (int k = 0; k < 8; k++) m_ctrl[k] = c_CTRL_RESET;
      end else if (clr) begin
         m_cnt = count_in ? 32'h1 : 32'h0;
      end else if (count_in && (m_cnt != 32'hFFFF_FFFF)) begin
         m_cnt = m_cnt + 32'h1;
      end
      @(posedge axilClk);
      #1;
      count_in  = cnt_rand ? 1'($urandom_range(0, 1)) : 1'b0;
      status_in = $urandom;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0);
   endtask

   task automatic do_reset(input int n);
      axilRst = 1'b1;
      #1;
      for (int i = 0; i < n; i++) begin
         check_val("rst_rack", rack, 1'b0);
         check_val("rst_wack", wack, 1'b0);
         check_val("rst_dout", dout, 32'h0);
         cyc(1'b0);
      end
      axilRst = 1'b0;
      #1;
   endtask

   task automatic write_txn(input logic [17:0] addr, input logic [31:0] data, input int hold);
      logic [3:0] off;
      off   = addr[3:0];
      wstr  = 1'b1;
      waddr = addr;
      wdata = data;
      #1;
      check_val("wack_w0", wack, 1'b0);
      cyc(off == 4'h9);
      if (off < 4'h8) m_ctrl[off[2:0]] = data;
      for (int i = 1; i < hold; i++) begin
         check_val("wack_high", wack, 1'b1);
         check_val("pulse", pulse_out, (i == 1 && off == 4'hA) ? data : 32'h0);
         check_val("ctrl", ctrl, model_ctrl());
         cyc(1'b0);
      end
      wstr = 1'b0;
      #1;
      check_val("wack_fall", wack, 1'b0);
      check_val("pulse_fall", pulse_out, (hold == 1 && off == 4'hA) ? data : 32'h0);
      cyc(1'b0);
   endtask

   task automatic read_txn(input logic [17:0] addr, input int hold);
      logic [31:0] exp;
      rstr  = 1'b1;
      raddr = addr;
      exp   = model_read(addr[3:0]);
      #1;
      check_val("rack_r0", rack, 1'b0);
      check_val("dout_r0", dout, 32'h0);
      cyc(1'b0);
      for (int i = 1; i < hold; i++) begin
         check_val("rack", rack, (i >= 2) ? 1'b1 : 1'b0);
         check_val("dout", dout, (i >= 2) ? exp : 32'h0);
         cyc(1'b0);
      end
      rstr = 1'b0;
      #1;
      check_val("rack_fall", rack, 1'b0);
      check_val("dout_fall", dout, 32'h0);
      cyc(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rnd_data;
      logic [17:0] rnd_addr;

      axilRst   = 1'b1;
      rstr      = 1'b0;
      raddr     = '0;
      wstr      = 1'b0;
      waddr     = '0;
      wdata     = '0;
      status_in = '0;
      count_in  = 1'b0;
      cnt_rand  = 1'b0;
      m_cnt     = '0;
      for (int k = 0; k < 8; k++) m_ctrl[k] = '0;

      // Reset state
      do_reset(3);
      check_val("reset_ctrl", ctrl, {8{c_CTRL_RESET}});
      check_val("reset_pulse", pulse_out, 32'h0);
      idle(1);

      // Basic write and ID read
      write_txn(18'h00003, 32'hCAFE_0003, 5);
      check_val("ctrl3", ctrl[127:96], 32'hCAFE_0003);
      read_txn(18'h0000B, 6);
      read_txn(18'h00003, 4);

      // Pulse register
      write_txn(18'h0000A, 32'h0000_0005, 3);
      read_txn(18'h0000A, 3);

      // Counter saturation, then clear with a simultaneous event
      dut.r_event_cnt = 32'hFFFF_FFFE;
      m_cnt           = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         count_in = 1'b1;
         cyc(1'b0);
      end
      read_txn(18'h00009, 3);
      count_in = 1'b1;
      write_txn(18'h00009, 32'h1234_5678, 2);
      read_txn(18'h00009, 3);

      // Same-cycle read and write of register 0
      write_txn(18'h00000, 32'h0000_0011, 2);
      rstr  = 1'b1;
      raddr = 18'h00000;
      wstr  = 1'b1;
      waddr = 18'h2A500;
      wdata = 32'h0000_0022;
      #1;
      check_val("ovl_rack_r0", rack, 1'b0);
      cyc(1'b0);
      m_ctrl[0] = 32'h0000_0022;
      check_val("ovl_rack_r1", rack, 1'b0);
      check_val("ovl_wack_w1", wack, 1'b1);
      cyc(1'b0);
      check_val("ovl_rack_r2", rack, 1'b1);
      check_val("ovl_dout_old", dout, 32'h0000_0011);
      cyc(1'b0);
      rstr = 1'b0;
      wstr = 1'b0;
      #1;
      check_val("ovl_rack_fall", rack, 1'b0);
      check_val("ovl_wack_fall", wack, 1'b0);
      cyc(1'b0);
      read_txn(18'h00000, 3);

      // Reset during an acknowledged write, strobe held across release
      wstr  = 1'b1;
      waddr = 18'h00005;
      wdata = 32'h5555_AAAA;
      #1;
      cyc(1'b0);
      m_ctrl[5] = 32'h5555_AAAA;
      check_val("pre_rst_wack", wack, 1'b1);
      do_reset(2);
      check_val("rst_ctrl", ctrl, {8{c_CTRL_RESET}});
      for (int i = 0; i < 3; i++) begin
         check_val("held_wack", wack, 1'b0);
         cyc(1'b0);
      end
      wstr = 1'b0;
      #1;
      cyc(1'b0);
      write_txn(18'h00006, 32'h0BAD_F00D, 3);

      // Randomized transactions
      cnt_rand = 1'b1;
      for (int n = 0; n < 150; n++) begin
         rnd_addr = 18'($urandom);
         rnd_data = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 1) == 0) begin
            read_txn(rnd_addr, int'($urandom_range(1, 5)));
         end else begin
            write_txn(rnd_addr, rnd_data, int'($urandom_range(1, 5)));
         end
         idle(int'($urandom_range(0, 2)));
      end
      cnt_rand = 1'b0;
      idle(1);
      check_val("final_ctrl", ctrl, model_ctrl());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
